shift_reg_tapped: RTL and testbench
===================================

SHIFT_REG_TAPPED -- requirements
Module: shift_reg_tapped

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each stage.
REQ-002 SHALL have parameter DEPTH, default 128, number of stages (legal range 2..1024).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  operation enable; when 0 all state holds regardless of mode.
REQ-006 SHALL have port mode  input  2  operation select: 00 shift, 01 rotate, 10 hold, 11 clear.
REQ-007 SHALL have port din  input  WIDTH  serial data into stage 0.
REQ-008 SHALL have port tap_sel  input  clog2(DEPTH)  index of the stage driven onto dout.
REQ-009 SHALL have port dout  output  WIDTH  contents of stage tap_sel.
REQ-010 SHALL have port dout_valid  output  1  high when stage tap_sel holds data written since the last reset/clear.
REQ-011 SHALL have port fill  output  clog2(DEPTH+1)  count of valid stages, saturating at DEPTH.
REQ-012 SHALL have port full  output  1  high when fill == DEPTH.

Function
REQ-013 SHALL hold DEPTH stages, stage 0 at input side, stage DEPTH-1 at far end.
REQ-014 en=1, mode=00: stage[0] <= din; stage[i] <= stage[i-1] for i=1..DEPTH-1; fill <= min(fill+1, DEPTH).
REQ-015 en=1, mode=01: stage[0] <= stage[DEPTH-1]; stage[i] <= stage[i-1]; din ignored; fill unchanged.
REQ-016 en=1, mode=10: all stages and fill hold.
REQ-017 en=1, mode=11: all stages <= 0; fill <= 0 on the same edge.
REQ-018 en=0: stages and fill hold for every mode value, including 11.
REQ-019 dout SHALL be a combinational select of registered stage[tap_sel]; a tap_sel change is visible the same cycle, no added latency.
REQ-020 Latency: a word sampled on din at an enabled shift edge SHALL appear on dout after exactly tap_sel+1 enabled shift edges (edges with en=0 or mode=10 do not count).
REQ-021 dout_valid SHALL equal (fill > tap_sel), combinationally.
REQ-022 tap_sel >= DEPTH (non-power-of-two DEPTH): dout = 0, dout_valid = 0.
REQ-023 fill SHALL saturate at DEPTH; further shifts keep fill = DEPTH, full = 1; oldest word is discarded from stage DEPTH-1.
REQ-024 Rotate with fill < DEPTH: data moves, fill is unchanged; dout_valid still follows REQ-021 (fill reflects count, not position).
REQ-025 Unused encodings: none; all four mode values are defined.

Reset
REQ-026 rst=1 at a rising edge: all stages <= 0, fill <= 0; hence dout = 0, dout_valid = 0, full = 0.
REQ-027 rst SHALL take priority over en and mode on the same edge, including mid-shift or mid-rotate.
REQ-028 First operation after rst deassert SHALL occur on the first edge with rst=0 and en=1.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-029 Reset then shift 0x11,0x22,0x33 with tap_sel=2 -> dout_valid rises after 3rd edge, dout=0x11; fill=3, full=0.
REQ-030 Shift 0xA1..0xA6 (6 words) -> fill=4, full=1; stage contents 0xA6,0xA5,0xA4,0xA3 for tap 0..3.
REQ-031 Full with 0xA6..0xA3 (tap 0..3), two rotate edges -> tap 0..3 read 0xA4,0xA3,0xA6,0xA5; fill stays 4.
REQ-032 Shift 0x5A with en toggling 1,0,0,1 and mode=10 on one enabled edge -> fill advances only on edges with en=1 and mode=00; tap 1 shows 0x5A after second counted shift.
REQ-033 fill=4, mode=11 en=1 -> next cycle all taps 0, fill=0, dout_valid=0; same stimulus with en=0 -> no change.
REQ-034 Assert rst during a rotate edge with fill=3 -> fill=0, all taps 0; DEPTH=5, tap_sel=6 -> dout=0, dout_valid=0.

Source files
------------

// File: rtl/shift_reg_tapped.sv
// -----------------------------------------------------------------------------
// shift_reg_tapped
//
// Purpose:
//   DEPTH-stage, WIDTH-bit shift register with a runtime-selectable read tap.
//   The register can shift new data in, rotate its contents end-around, hold,
//   or clear. It tracks how many stages hold data written since the last reset
//   or clear, so a reader can tell whether the selected tap is meaningful.
//
// Ports:
//   clk        - sole clock; all state changes on its rising edge
//   rst        - synchronous, active-high reset (overrides en/mode)
//   en         - operation enable; when low all state holds
//   mode       - 00 shift, 01 rotate, 10 hold, 11 clear
//   din        - serial data into stage 0 (used by shift only)
//   tap_sel    - index of the stage driven onto dout
//   dout       - contents of stage tap_sel (0 when tap_sel >= DEPTH)
//   dout_valid - high when fill > tap_sel
//   fill       - count of valid stages, saturating at DEPTH
//   full       - high when fill == DEPTH
// -----------------------------------------------------------------------------
module shift_reg_tapped #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128,
    localparam int TAP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  din,
    input  logic [TAP_W-1:0]  tap_sel,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic [FILL_W-1:0] fill,
    output logic              full
);

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  stage_reg  [DEPTH];
    logic [WIDTH-1:0]  stage_next [DEPTH];
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;

    logic shift_en;
    logic rotate_en;
    logic clear_en;

    assign shift_en  = en && (mode == MODE_SHIFT);
    assign rotate_en = en && (mode == MODE_ROTATE);
    assign clear_en  = en && (mode == MODE_CLEAR);

    // Shift and rotate move data identically along the chain; they differ
    // only in what enters stage 0 (din versus the far-end stage).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = rotate_en ? stage_reg[DEPTH-1] : din;
            end else begin : g_body
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (shift_en || rotate_en) begin
            stage_reg <= stage_next;
        end
    end

    // fill counts words written, not their position, so a rotate leaves it
    // alone even when the valid words wrap past the far end.
    always_comb begin
        fill_next = fill_reg;
        if (clear_en) begin
            fill_next = '0;
        end else if (shift_en && (fill_reg != FILL_MAX)) begin
            fill_next = fill_reg + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg <= '0;
        end else begin
            fill_reg <= fill_next;
        end
    end

    // A tap past the last stage (possible when DEPTH is not a power of two)
    // reads as zero. dout_valid needs no such guard: fill never exceeds
    // DEPTH, so fill > tap_sel is already false there.
    always_comb begin
        dout = '0;
        if (32'(tap_sel) < 32'(DEPTH)) begin
            dout = stage_reg[tap_sel];
        end
    end

    assign dout_valid = 32'(fill_reg) > 32'(tap_sel);
    assign fill       = fill_reg;
    assign full       = (fill_reg == FILL_MAX);

endmodule

// File: tb/tb_shift_reg_tapped.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_tapped
//
// Directed and random stimulus for shift_reg_tapped. A DEPTH=4 instance is
// the main subject; a DEPTH=5 instance shares the same control inputs so the
// out-of-range tap behaviour can be checked. Expected values come from a
// queue-based reference model of the stage contents plus a fill counter.
// -----------------------------------------------------------------------------
module tb_shift_reg_tapped;

    localparam int W  = 8;
    localparam int D4 = 4;
    localparam int D5 = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] din;

    logic [1:0]   tap4;
    logic [W-1:0] dout4;
    logic         valid4;
    logic [2:0]   fill4;
    logic         full4;

    logic [2:0]   tap5;
    logic [W-1:0] dout5;
    logic         valid5;
    logic [2:0]   fill5;
    logic         full5;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 of each queue is stage 0.
    logic [W-1:0] q4 [$];
    logic [W-1:0] q5 [$];
    int           mfill4;
    int           mfill5;

    always #5 clk = ~clk;

    shift_reg_tapped #(.WIDTH(W), .DEPTH(D4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .tap_sel(tap4), .dout(dout4), .dout_valid(valid4),
        .fill(fill4), .full(full4)
    );

    shift_reg_tapped #(.WIDTH(W), .DEPTH(D5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .tap_sel(tap5), .dout(dout5), .dout_valid(valid5),
        .fill(fill5), .full(full5)
    );

    function automatic void model_reset();
        q4.delete();
        q5.delete();
        for (int i = 0; i < D4; i++) q4.push_back('0);
        for (int i = 0; i < D5; i++) q5.push_back('0);
        mfill4 = 0;
        mfill5 = 0;
    endfunction

    function automatic void model_step(logic r, logic e, logic [1:0] m, logic [W-1:0] d);
        logic [W-1:0] w;
        if (r) begin
            model_reset();
        end else if (e) begin
            case (m)
                2'b00: begin
                    q4.push_front(d); w = q4.pop_back();
                    q5.push_front(d); w = q5.pop_back();
                    if (mfill4 < D4) mfill4++;
                    if (mfill5 < D5) mfill5++;
                end
                2'b01: begin
                    w = q4.pop_back(); q4.push_front(w);
                    w = q5.pop_back(); q5.push_front(w);
                end
                2'b11: model_reset();
                default: ;
            endcase
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given controls; inputs change 1ns after an edge.
    task automatic tick(logic r, logic e, logic [1:0] m, logic [W-1:0] d);
        rst = r; en = e; mode = m; din = d;
        @(posedge clk);
        model_step(r, e, m, d);
        #1;
    endtask

    // Sweep every tap of the DEPTH=4 instance against the model.
    task automatic check_all4(string tag);
        for (int t = 0; t < D4; t++) begin
            tap4 = 2'(t);
            #1;
            chk($sformatf("%s.dout[%0d]", tag, t), 32'(dout4), 32'(q4[t]));
            chk($sformatf("%s.valid[%0d]", tag, t), 32'(valid4), 32'(mfill4 > t));
        end
        chk({tag, ".fill"}, 32'(fill4), 32'(mfill4));
        chk({tag, ".full"}, 32'(full4), 32'(mfill4 == D4));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; din = '0; tap4 = '0; tap5 = '0;
        model_reset();

        // Reset state
        tick(1'b1, 1'b1, 2'b00, 8'hFF);
        check_all4("reset");

        // Three shifts, watching tap 2 become valid on the third edge
        tap4 = 2'd2;
        tick(1'b0, 1'b1, 2'b00, 8'h11);
        tap4 = 2'd2; #1;
        chk("fill3.valid_e1", 32'(valid4), 32'd0);
        tick(1'b0, 1'b1, 2'b00, 8'h22);
        tap4 = 2'd2; #1;
        chk("fill3.valid_e2", 32'(valid4), 32'd0);
        tick(1'b0, 1'b1, 2'b00, 8'h33);
        tap4 = 2'd2; #1;
        chk("fill3.valid_e3", 32'(valid4), 32'd1);
        chk("fill3.dout", 32'(dout4), 32'h11);
        chk("fill3.fill", 32'(fill4), 32'd3);
        chk("fill3.full", 32'(full4), 32'd0);

        // Six more shifts saturate fill and discard the oldest words
        for (int i = 1; i <= 6; i++) tick(1'b0, 1'b1, 2'b00, 8'(8'hA0 + i));
        check_all4("sat");
        tap4 = 2'd3; #1;
        chk("sat.tap3_const", 32'(dout4), 32'hA3);

        // Two rotates: A6 A5 A4 A3 -> A4 A3 A6 A5
        tick(1'b0, 1'b1, 2'b01, 8'hEE);
        tick(1'b0, 1'b1, 2'b01, 8'hEE);
        check_all4("rot");
        tap4 = 2'd0; #1;
        chk("rot.tap0_const", 32'(dout4), 32'hA4);

        // Clear with en=0 changes nothing; with en=1 empties everything
        tick(1'b0, 1'b0, 2'b11, 8'h00);
        check_all4("clr_dis");
        tick(1'b0, 1'b1, 2'b11, 8'h00);
        check_all4("clr");

        // Gated shifts: only en=1 with mode=00 counts
        tick(1'b0, 1'b1, 2'b00, 8'h5A);
        tick(1'b0, 1'b0, 2'b00, 8'h01);
        tick(1'b0, 1'b0, 2'b00, 8'h02);
        tick(1'b0, 1'b1, 2'b10, 8'h03);
        check_all4("gate_a");
        tick(1'b0, 1'b1, 2'b00, 8'h77);
        check_all4("gate_b");
        tap4 = 2'd1; #1;
        chk("gate.tap1_const", 32'(dout4), 32'h5A);

        // Reset wins over a rotate with fill=3
        tick(1'b0, 1'b1, 2'b00, 8'h99);
        tick(1'b0, 1'b1, 2'b01, 8'h00);
        check_all4("pre_rst");
        tick(1'b1, 1'b1, 2'b01, 8'h00);
        check_all4("rst_rot");

        // DEPTH=5 instance: tap beyond the last stage reads as zero/invalid
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 2'b00, 8'($urandom_range(1, 255)));
        tap5 = 3'd6; #1;
        chk("d5.tap6_dout", 32'(dout5), 32'd0);
        chk("d5.tap6_valid", 32'(valid5), 32'd0);
        tap5 = 3'd4; #1;
        chk("d5.tap4_dout", 32'(dout5), 32'(q5[4]));
        chk("d5.tap4_valid", 32'(valid5), 32'd1);
        chk("d5.full", 32'(full5), 32'd1);

        // Random stress: clears and resets kept rare so the chain fills up
        for (int n = 0; n < 300; n++) begin
            logic       r;
            logic       e;
            logic [1:0] m;
            int         tt;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            tick(r, e, m, 8'($urandom));
            check_all4($sformatf("rnd%0d", n));
            tt   = $urandom_range(0, 7);
            tap5 = 3'(tt);
            #1;
            chk($sformatf("rnd%0d.d5dout", n), 32'(dout5), (tt < D5) ? 32'(q5[tt]) : 32'd0);
            chk($sformatf("rnd%0d.d5valid", n), 32'(valid5), 32'(mfill5 > tt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
